// File: rtl/ddr3_avalon_bridge.sv
// Bridges the Canny core's single-beat DDR3 request/complete handshake onto a
// single-transaction Avalon-MM master with base-address offset and read timeout.
module ddr3_avalon_bridge #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 128,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = ADDR_W'(32'h3000_0000),
  parameter int                TIMEOUT_CYCLES = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   sdram_address,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   write_data_input,
  output logic [DATA_W-1:0]   read_data,
  output logic                write_complete,
  output logic                read_complete,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [7:0]          avm_burstcount,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                busy,
  output logic                timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_WAIT,
    DONE_WR,
    DONE_RD
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] req_addr;

  // Offset then align to the 16-byte beat; the sum wraps modulo 2^ADDR_W.
  assign req_addr = (sdram_address + BASE_ADDR) & ~ADDR_W'(15);

  // Single-beat, full-width transfers only.
  assign avm_byteenable = '1;
  assign avm_burstcount = 8'd1;

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would leak new values mid-block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      read_data      <= '0;
      write_complete <= 1'b0;
      read_complete  <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      write_complete <= 1'b0;
      read_complete  <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            avm_address   <= req_addr;
            avm_writedata <= write_data_input;
            avm_write     <= 1'b1;
            busy          <= 1'b1;
            state         <= WR_REQ;
          end else if (rd_en) begin
            avm_address <= req_addr;
            avm_read    <= 1'b1;
            busy        <= 1'b1;
            state       <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (!avm_waitrequest) begin
            avm_write      <= 1'b0;
            write_complete <= 1'b1;
            state          <= DONE_WR;
          end
        end
        RD_REQ: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            wait_cnt <= '0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // A response arriving on the timeout cycle still wins.
          if (avm_readdatavalid) begin
            read_data     <= avm_readdata;
            read_complete <= 1'b1;
            state         <= DONE_RD;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            read_data     <= '0;
            timeout_err   <= 1'b1;
            read_complete <= 1'b1;
            state         <= DONE_RD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE_WR, DONE_RD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_avalon_bridge.sv
// Randomized self-checking bench for ddr3_avalon_bridge: a cycle-level model of
// the requester and Avalon slave, with a second instance exercising address wrap.
module tb_ddr3_avalon_bridge;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 128;
  localparam int          T      = 7;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] BASE2  = 32'hFFFF_FFF0;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] sdram_address;
  logic              rd_en, wr_en;
  logic [DATA_W-1:0] write_data_input;
  logic              avm_waitrequest, avm_readdatavalid;
  logic [DATA_W-1:0] avm_readdata;

  logic [DATA_W-1:0]   read_data, avm_writedata;
  logic                write_complete, read_complete, avm_read, avm_write, busy, timeout_err;
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [7:0]          avm_burstcount;

  logic [DATA_W-1:0]   w_read_data, w_avm_writedata;
  logic                w_write_complete, w_read_complete, w_avm_read, w_avm_write, w_busy, w_timeout_err;
  logic [ADDR_W-1:0]   w_avm_address;
  logic [DATA_W/8-1:0] w_avm_byteenable;
  logic [7:0]          w_avm_burstcount;

  ddr3_avalon_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .sdram_address(sdram_address), .rd_en(rd_en), .wr_en(wr_en),
    .write_data_input(write_data_input), .read_data(read_data), .write_complete(write_complete),
    .read_complete(read_complete), .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid), .busy(busy),
    .timeout_err(timeout_err)
  );

  ddr3_avalon_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE2), .TIMEOUT_CYCLES(T)) dut_wrap (
    .clk(clk), .rst(rst), .sdram_address(sdram_address), .rd_en(rd_en), .wr_en(wr_en),
    .write_data_input(write_data_input), .read_data(w_read_data), .write_complete(w_write_complete),
    .read_complete(w_read_complete), .avm_address(w_avm_address), .avm_read(w_avm_read),
    .avm_write(w_avm_write), .avm_writedata(w_avm_writedata), .avm_byteenable(w_avm_byteenable),
    .avm_burstcount(w_avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid), .busy(w_busy),
    .timeout_err(w_timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wc_pulses = 0;
  int rc_pulses = 0;
  logic [DATA_W-1:0] exp_rd;
  logic              exp_err;

  always @(negedge clk) begin
    if (write_complete) wc_pulses++;
    if (read_complete)  rc_pulses++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Avalon address the specification asks for: offset sum modulo 2^32, low nibble dropped.
  function automatic logic [31:0] map_addr(input logic [31:0] a, input logic [31:0] base);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, base};
    return {s[31:4], 4'h0};
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [127:0] data, input int n_wait);
    int wc0 = wc_pulses;
    sdram_address    = addr;
    write_data_input = data;
    wr_en            = 1'b1;
    avm_waitrequest  = 1'b0;
    for (int c = 1; c <= n_wait + 1; c++) begin
      step();
      sdram_address    = $urandom;
      write_data_input = {4{$urandom}};
      avm_waitrequest  = (c <= n_wait);
      check("wr_avm_write", 128'(avm_write), 128'd1);
      check("wr_no_read", 128'(avm_read), 128'd0);
      check("wr_addr", 128'(avm_address), 128'(map_addr(addr, BASE)));
      check("wr_addr_wrap", 128'(w_avm_address), 128'(map_addr(addr, BASE2)));
      check("wr_data", avm_writedata, data);
      check("wr_be", 128'(avm_byteenable), 128'(16'hFFFF));
      check("wr_busy", 128'(busy), 128'd1);
      check("wr_early_pulse", 128'(write_complete), 128'd0);
    end
    step();
    avm_waitrequest = 1'b0;
    check("wr_complete", 128'(write_complete), 128'd1);
    check("wr_avm_write_drop", 128'(avm_write), 128'd0);
    wr_en         = 1'b0;
    sdram_address = addr;
    step();
    check("wr_idle_busy", 128'(busy), 128'd0);
    check("wr_pulse_count", 128'(wc_pulses - wc0), 128'd1);
    check("wr_rd_data_hold", read_data, exp_rd);
  endtask

  // lat > T means the slave never answers and the read must time out.
  task automatic do_read(input logic [31:0] addr, input logic [127:0] data, input int n_wait, input int lat);
    int  rc0 = rc_pulses;
    bit  to  = (lat > T);
    int  n   = to ? T + 1 : lat;
    sdram_address   = addr;
    rd_en           = 1'b1;
    avm_waitrequest = 1'b0;
    for (int c = 1; c <= n_wait + 1; c++) begin
      step();
      sdram_address   = $urandom;
      avm_waitrequest = (c <= n_wait);
      check("rd_avm_read", 128'(avm_read), 128'd1);
      check("rd_no_write", 128'(avm_write), 128'd0);
      check("rd_addr", 128'(avm_address), 128'(map_addr(addr, BASE)));
      check("rd_addr_wrap", 128'(w_avm_address), 128'(map_addr(addr, BASE2)));
      check("rd_busy", 128'(busy), 128'd1);
      check("rd_data_hold", read_data, exp_rd);
    end
    for (int k = 1; k <= n; k++) begin
      step();
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = !to && (k == n);
      avm_readdata      = (!to && k == n) ? data : {4{$urandom}};
      check("rd_wait_read_low", 128'(avm_read), 128'd0);
      check("rd_wait_no_pulse", 128'(read_complete), 128'd0);
    end
    step();
    avm_readdatavalid = 1'b0;
    if (to) begin
      exp_rd  = '0;
      exp_err = 1'b1;
    end else begin
      exp_rd = data;
    end
    check("rd_complete", 128'(read_complete), 128'd1);
    check("rd_data", read_data, exp_rd);
    check("rd_timeout_err", 128'(timeout_err), 128'(exp_err));
    rd_en = 1'b0;
    step();
    check("rd_idle_busy", 128'(busy), 128'd0);
    check("rd_pulse_count", 128'(rc_pulses - rc0), 128'd1);
  endtask

  task automatic late_valid();
    avm_readdatavalid = 1'b1;
    avm_readdata      = {4{$urandom}};
    step();
    avm_readdatavalid = 1'b0;
    check("late_rd_data", read_data, exp_rd);
    check("late_no_pulse", 128'(read_complete), 128'd0);
    check("late_busy", 128'(busy), 128'd0);
  endtask

  // Abort a stalled write (in WR_REQ) or a read waiting for data (in RD_WAIT).
  task automatic reset_mid(input bit is_wr);
    int wc0 = wc_pulses;
    int rc0 = rc_pulses;
    sdram_address    = $urandom;
    write_data_input = {4{$urandom}};
    wr_en            = is_wr;
    rd_en            = !is_wr;
    avm_waitrequest  = is_wr;
    step();
    step();
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    step();
    rst     = 1'b0;
    exp_rd  = '0;
    exp_err = 1'b0;
    avm_waitrequest = 1'b0;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_avm_read", 128'(avm_read), 128'd0);
    check("rst_avm_write", 128'(avm_write), 128'd0);
    check("rst_rd_data", read_data, 128'd0);
    check("rst_err", 128'(timeout_err), 128'd0);
    late_valid();
    check("rst_no_wc", 128'(wc_pulses - wc0), 128'd0);
    check("rst_no_rc", 128'(rc_pulses - rc0), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // NOTE: stimulus is driven with blocking assignments #1 after the edge so
    // the DUT samples stable values on the next rising edge.
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; sdram_address = '0; write_data_input = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    exp_rd = '0; exp_err = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset_avm_read", 128'(avm_read), 128'd0);
    check("reset_avm_write", 128'(avm_write), 128'd0);
    check("reset_wc", 128'(write_complete), 128'd0);
    check("reset_rc", 128'(read_complete), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_err", 128'(timeout_err), 128'd0);
    check("reset_rd_data", read_data, 128'd0);
    check("reset_addr", 128'(avm_address), 128'd0);
    check("reset_wdata", avm_writedata, 128'd0);
    check("reset_be", 128'(avm_byteenable), 128'(16'hFFFF));
    check("reset_burst", 128'(avm_burstcount), 128'd1);

    do_write(32'h40, {16{8'hA5}}, 0);
    do_read(32'h1234F, {4{32'hDEAD_BEEF}}, 3, 5);

    rd_en = 1'b1;
    do_write(32'h80, {4{32'h0BAD_F00D}}, 1);
    do_read(32'h80, {4{32'h1357_9BDF}}, 0, 2);

    do_read(32'h100, {4{32'h5555_AAAA}}, 1, T + 1);
    late_valid();
    do_read(32'h110, {4{32'h2468_ACE0}}, 0, 1);

    do_write(32'h20, {4{32'hCAFE_F00D}}, 0);
    do_read(32'hD000_0020, {4{32'h0F0F_F0F0}}, 2, T);

    for (int i = 0; i < 40; i++) begin
      logic [31:0]  a = $urandom;
      logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
      int           kind = $urandom_range(0, 2);
      int           nw = $urandom_range(0, 3);
      int           lat = ($urandom_range(0, 7) == 0) ? T + 1 : $urandom_range(1, T);
      if (kind == 0) begin
        do_write(a, d, nw);
      end else if (kind == 1) begin
        do_read(a, d, nw, lat);
      end else begin
        rd_en = 1'b1;
        do_write(a, d, nw);
        do_read(a, ~d, $urandom_range(0, 2), lat);
      end
    end

    reset_mid(1'b0);
    do_read(32'h200, {4{32'h7777_1111}}, 0, 3);
    reset_mid(1'b1);
    do_write(32'h210, {4{32'h8888_2222}}, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
